// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates plus hsync/vsync/blank and line/frame
// strobes, all registered together so every output describes the pixel in hcount/vcount.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_ACTIVE  = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int HW        = 11,
   parameter int VW        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic [HW-1:0] hcount,
   output logic [VW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One extra bit so sync-end boundaries equal to the total never overflow.
   localparam logic [HW:0] H_LAST   = (HW+1)'(H_TOTAL - 1);
   localparam logic [HW:0] H_ACT    = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0] HS_START = (HW+1)'(H_ACTIVE + H_FP);
   localparam logic [HW:0] HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW:0] V_LAST   = (VW+1)'(V_TOTAL - 1);
   localparam logic [VW:0] V_ACT    = (VW+1)'(V_ACTIVE);
   localparam logic [VW:0] VS_START = (VW+1)'(V_ACTIVE + V_FP);
   localparam logic [VW:0] VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_next;
   logic [VW-1:0] v_next;
   logic [HW:0]   h_cur_x, h_nx;
   logic [VW:0]   v_cur_x, v_nx;
   logic          h_wrap, frame_wrap;
   logic          hsync_next, vsync_next, blank_next;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      h_next     = hcount;
      v_next     = vcount;
      h_cur_x    = {1'b0, hcount};
      v_cur_x    = {1'b0, vcount};
      h_wrap     = (h_cur_x >= H_LAST);
      frame_wrap = h_wrap && (v_cur_x >= V_LAST);

      h_next = h_wrap ? '0 : hcount + 1'b1;
      // Out-of-range lines snap back to 0 on the next enabled edge.
      if (v_cur_x > V_LAST)
         v_next = '0;
      else if (h_wrap)
         v_next = (v_cur_x >= V_LAST) ? '0 : vcount + 1'b1;

      h_nx       = {1'b0, h_next};
      v_nx       = {1'b0, v_next};
      hsync_next = (h_nx >= HS_START && h_nx < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_next = (v_nx >= VS_START && v_nx < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      blank_next = (h_nx >= H_ACT) || (v_nx >= V_ACT);
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked block.
      if (rst) begin
         hcount      <= '0;
         vcount      <= '0;
         frame_count <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         blank       <= 1'b0;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else if (pix_en) begin
         hcount      <= h_next;
         vcount      <= v_next;
         hsync       <= hsync_next;
         vsync       <= vsync_next;
         blank       <= blank_next;
         line_start  <= (h_next == '0);
         frame_start <= (h_next == '0) && (v_next == '0);
         if (frame_wrap)
            frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-timing instance run
// side by side against a pixel-index reference model under random pix_en gating.
module tb_vga_timing_gen;

   typedef struct packed {
      int h;
      int v;
      bit hs;
      bit vs;
      bit bl;
      bit ls;
      bit fs;
   } exp_t;

   localparam int D_TOT = 1344 * 806;
   localparam int S_TOT = 14 * 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en_d = 1'b0;
   logic        pix_en_s = 1'b0;

   logic [10:0] hcount_d;
   logic [9:0]  vcount_d;
   logic        hsync_d, vsync_d, blank_d, line_start_d, frame_start_d;
   logic [7:0]  frame_count_d;

   logic [3:0]  hcount_s;
   logic [2:0]  vcount_s;
   logic        hsync_s, vsync_s, blank_s, line_start_s, frame_start_s;
   logic [7:0]  frame_count_s;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: linear pixel index within the frame plus completed-frame count.
   int idx_d = 0, fc_d = 0;
   int idx_s = 0, fc_s = 0;

   // Frame period measurement on the small instance, taken from its own outputs.
   int en_cnt_s = 0;
   bit period_valid = 1'b0;
   bit prev_fs_s = 1'b1;
   int prev_fc_s = 0;
   bit wrap_seen = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen dut_d (
      .clk(clk), .rst(rst), .pix_en(pix_en_d),
      .hcount(hcount_d), .vcount(vcount_d), .hsync(hsync_d), .vsync(vsync_d),
      .blank(blank_d), .line_start(line_start_d), .frame_start(frame_start_d),
      .frame_count(frame_count_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(4), .VW(3)
   ) dut_s (
      .clk(clk), .rst(rst), .pix_en(pix_en_s),
      .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
      .blank(blank_s), .line_start(line_start_s), .frame_start(frame_start_s),
      .frame_count(frame_count_s)
   );

   function automatic exp_t model(input int idx, input int ha, input int hfp, input int hsw,
                                  input int hbp, input int va, input int vfp, input int vsw,
                                  input bit hp, input bit vp);
      exp_t e;
      int ht;
      ht   = ha + hfp + hsw + hbp;
      e.h  = idx % ht;
      e.v  = idx / ht;
      e.hs = (e.h >= ha + hfp && e.h < ha + hfp + hsw) ? hp : !hp;
      e.vs = (e.v >= va + vfp && e.v < va + vfp + vsw) ? vp : !vp;
      e.bl = (e.h >= ha) || (e.v >= va);
      e.ls = (e.h == 0);
      e.fs = (e.h == 0) && (e.v == 0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, expv);
      end
   endtask

   task automatic compare_all();
      exp_t e;
      e = model(idx_d, 1024, 24, 136, 160, 768, 3, 6, 1'b0, 1'b0);
      check("d_hcount", 32'(hcount_d), e.h);
      check("d_vcount", 32'(vcount_d), e.v);
      check("d_hsync", 32'(hsync_d), 32'(e.hs));
      check("d_vsync", 32'(vsync_d), 32'(e.vs));
      check("d_blank", 32'(blank_d), 32'(e.bl));
      check("d_line_start", 32'(line_start_d), 32'(e.ls));
      check("d_frame_start", 32'(frame_start_d), 32'(e.fs));
      check("d_frame_count", 32'(frame_count_d), fc_d);
      e = model(idx_s, 8, 2, 3, 1, 4, 1, 2, 1'b1, 1'b1);
      check("s_hcount", 32'(hcount_s), e.h);
      check("s_vcount", 32'(vcount_s), e.v);
      check("s_hsync", 32'(hsync_s), 32'(e.hs));
      check("s_vsync", 32'(vsync_s), 32'(e.vs));
      check("s_blank", 32'(blank_s), 32'(e.bl));
      check("s_line_start", 32'(line_start_s), 32'(e.ls));
      check("s_frame_start", 32'(frame_start_s), 32'(e.fs));
      check("s_frame_count", 32'(frame_count_s), fc_s);
   endtask

   // One clock: drive inputs, advance the model on the edge, then sample 1 time unit later.
   task automatic step(input bit r, input bit ed, input bit es);
      rst      = r;
      pix_en_d = ed;
      pix_en_s = es;
      @(posedge clk);
      if (r) begin
         idx_d = 0; fc_d = 0;
         idx_s = 0; fc_s = 0;
         en_cnt_s = 0;
         period_valid = 1'b1;
      end else begin
         if (ed) begin
            idx_d++;
            if (idx_d == D_TOT) begin idx_d = 0; fc_d = (fc_d + 1) % 256; end
         end
         if (es) begin
            idx_s++;
            en_cnt_s++;
            if (idx_s == S_TOT) begin idx_s = 0; fc_s = (fc_s + 1) % 256; end
         end
      end
      #1;
      compare_all();
      if (!r && frame_start_s && !prev_fs_s) begin
         if (period_valid) check("s_frame_period", en_cnt_s, S_TOT);
         en_cnt_s = 0;
         period_valid = 1'b1;
      end
      if (!r && prev_fc_s == 255 && frame_count_s == 8'd0) wrap_seen = 1'b1;
      prev_fs_s = frame_start_s;
      prev_fc_s = int'(frame_count_s);
   endtask

   initial begin
      int n;

      // Reset held for 5 cycles with random enables; reset must override them.
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom % 2), 1'($urandom % 2));
      check("rst_hsync_high", 32'(hsync_d), 1);
      check("rst_vsync_high", 32'(vsync_d), 1);
      check("rst_frame_start", 32'(frame_start_d), 1);

      step(1'b0, 1'b1, 1'b1);
      check("first_edge_hcount", 32'(hcount_d), 1);
      check("first_edge_line_start", 32'(line_start_d), 0);

      // Three full default lines ungated: hsync edges, blank, hcount wrap.
      for (int i = 0; i < 3 * 1344; i++) step(1'b0, 1'b1, 1'($urandom % 2));

      // 50% random gating on both instances.
      for (int i = 0; i < 6000; i++) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));

      // Mid-frame reset once the default instance shows hcount 600.
      n = 0;
      while (hcount_d != 11'd600 && n < 3000) begin
         step(1'b0, 1'b1, 1'($urandom % 2));
         n++;
      end
      check("reach_h600", 32'(hcount_d), 600);
      step(1'b1, 1'b1, 1'b1);
      check("midrst_hcount", 32'(hcount_d), 0);
      check("midrst_frame_count", 32'(frame_count_d), 0);
      step(1'b0, 1'b1, 1'b1);
      check("midrst_restart_h", 32'(hcount_d), 1);
      check("midrst_restart_v", 32'(vcount_d), 0);

      // Run the small instance past 256 frames to see frame_count wrap.
      n = 0;
      while (!wrap_seen && n < 30000) begin
         step(1'b0, 1'($urandom % 2), 1'b1);
         n++;
      end
      check("s_frame_count_wrap", 32'(wrap_seen), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
